// File: rtl/jam_pkg.sv
// Shared types and sizes for the JAM cost server and its cost table.
package jam_pkg;

  localparam int N_WORKER    = 8;
  localparam int N_JOB       = 8;
  localparam int COST_W      = 7;
  localparam int MINCOST_W   = 9;
  localparam int MATCH_W     = 4;
  localparam int TABLE_BEATS = 64;
  localparam int LOAD_BEATS  = 66;

  typedef enum logic [1:0] {LOAD, HOLD, RUN, DONE} srv_state_t;

  typedef logic [COST_W-1:0] cost_t;

endpackage

// File: rtl/jam_cost_table.sv
// 64-entry worker/job cost register file: synchronous write, asynchronous read
// so JAM sees Cost in the same cycle it presents W/J.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic       CLK,
  input  logic       we,
  input  logic [5:0] waddr,
  input  cost_t      wdata,
  input  logic [5:0] raddr,
  output cost_t      rdata
);

  cost_t mem [TABLE_BEATS];

  // Contents survive reset; a fresh load rewrites every entry.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// Cost-table responder and result checker for JAM: loads table and golden
// values, holds JAM in reset, times the run and compares the reported result.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int RST_HOLD       = 3,
  parameter int CYC_W          = 31
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load_valid,
  input  logic [8:0]           load_data,
  output logic                 load_ready,
  output logic                 jam_rst,
  input  logic [2:0]           W,
  input  logic [2:0]           J,
  output cost_t                Cost,
  input  logic [8:0]           MinCost,
  input  logic [3:0]           MatchCount,
  input  logic                 Valid,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CYC_W-1:0]     cycle_count,
  output logic [8:0]           cap_min_cost,
  output logic [3:0]           cap_match_count
);

  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       HOLD_LAST    = 8'(RST_HOLD - 1);

  srv_state_t             state;
  logic [6:0]             beat_cnt;
  logic [7:0]             hold_cnt;
  logic [MINCOST_W-1:0]   gold_min_cost;
  logic [MATCH_W-1:0]     gold_match_count;
  logic                   beat;
  logic                   table_we;

  assign beat     = load_valid && load_ready;
  assign table_we = beat && (beat_cnt < 7'(TABLE_BEATS));

  jam_cost_table u_table (
    .CLK   (CLK),
    .we    (table_we),
    .waddr (beat_cnt[5:0]),
    .wdata (load_data[COST_W-1:0]),
    .raddr ({W, J}),
    .rdata (Cost)
  );

  // Valid is tested before the timeout so a result on the final cycle still counts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= LOAD;
      load_ready      <= 1'b1;
      jam_rst         <= 1'b1;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      cycle_count     <= '0;
      cap_min_cost    <= '0;
      cap_match_count <= '0;
      beat_cnt        <= '0;
      hold_cnt        <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 7'd1;
            if (beat_cnt == 7'(TABLE_BEATS)) gold_min_cost <= load_data;
            if (beat_cnt == 7'(LOAD_BEATS - 1)) begin
              gold_match_count <= load_data[MATCH_W-1:0];
              load_ready       <= 1'b0;
              hold_cnt         <= '0;
              state            <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            jam_rst <= 1'b0;
            state   <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          if (Valid) begin
            cap_min_cost    <= MinCost;
            cap_match_count <= MatchCount;
            pass            <= (MinCost == gold_min_cost) && (MatchCount == gold_match_count);
            done            <= 1'b1;
            state           <= DONE;
          end else if (cycle_count == TIMEOUT_LAST) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CYC_W'(1);
          end
        end
        DONE: begin
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized self-checking bench for jam_cost_server against a table/golden model.
module tb_jam_cost_server;
  import jam_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        load_valid;
  logic [8:0]  load_data;
  logic [2:0]  W, J;
  logic [8:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        Valid;

  logic        load_ready, jam_rst, done, pass, timeout;
  cost_t       Cost;
  logic [30:0] cycle_count;
  logic [8:0]  cap_min_cost;
  logic [3:0]  cap_match_count;

  logic        to_load_ready, to_jam_rst, to_done, to_pass, to_timeout;
  cost_t       to_cost;
  logic [30:0] to_cycle_count;
  logic [8:0]  to_cap_min_cost;
  logic [3:0]  to_cap_match_count;

  int model_cost [64];
  int gold_min, gold_match;
  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  jam_cost_server dut (
    .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid), .done(done),
    .pass(pass), .timeout(timeout), .cycle_count(cycle_count),
    .cap_min_cost(cap_min_cost), .cap_match_count(cap_match_count)
  );

  jam_cost_server #(.TIMEOUT_CYCLES(100)) dut_to (
    .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
    .load_ready(to_load_ready), .jam_rst(to_jam_rst), .W(W), .J(J), .Cost(to_cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid), .done(to_done),
    .pass(to_pass), .timeout(to_timeout), .cycle_count(to_cycle_count),
    .cap_min_cost(to_cap_min_cost), .cap_match_count(to_cap_match_count)
  );

  task automatic make_table(input bit identity);
    for (int i = 0; i < 64; i++)
      model_cost[i] = identity ? (((i / 8) == (i % 8)) ? 1 : 9) : int'($urandom_range(0, 127));
  endtask

  // Upper bits of table and match beats carry junk the server must ignore.
  function automatic logic [8:0] beat_word(input int idx);
    if (idx < 64) return {2'($urandom_range(0, 3)), 7'(model_cost[idx])};
    if (idx == 64) return 9'(gold_min);
    return {5'($urandom_range(0, 31)), 4'(gold_match)};
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1; load_valid = 1'b0; load_data = '0; Valid = 1'b0;
    MinCost = '0; MatchCount = '0; W = '0; J = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Streams all 66 beats, then checks the reset hold; returns at run cycle 0.
  task automatic load_all(input bit gaps);
    int acc = 0;
    int guard = 0;
    while (acc < 66 && guard < 2000) begin
      bit v;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_valid = v;
      load_data  = beat_word(acc);
      compared++;
      if (load_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL load_ready_high beat %0d: got %b expected 1", acc, load_ready);
      end
      @(negedge CLK);
      if (v) acc++;
      guard++;
    end
    load_valid = 1'b0;
    compared++;
    if (acc != 66) begin
      mismatched++;
      $display("[TB] FAIL load_budget: accepted %0d expected 66", acc);
    end
    compared++;
    if (load_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_ready_fall: got %b expected 0", load_ready);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge CLK);
      compared++;
      if (jam_rst !== (k < 3)) begin
        mismatched++;
        $display("[TB] FAIL jam_rst_hold cycle %0d: got %b expected %b", k, jam_rst, (k < 3));
      end
    end
    compared++;
    if (cycle_count !== 31'd0) begin
      mismatched++;
      $display("[TB] FAIL run_start_count: got %0d expected 0", cycle_count);
    end
  endtask

  task automatic fire_valid(input int min_cost, input int match_count);
    Valid = 1'b1; MinCost = 9'(min_cost); MatchCount = 4'(match_count);
    @(negedge CLK);
    Valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    compared++;
    if ({load_ready, jam_rst, done, pass, timeout} !== 5'b11000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 11000", {load_ready, jam_rst, done, pass, timeout});
    end
    compared++;
    if (cycle_count !== 31'd0 || cap_min_cost !== 9'd0 || cap_match_count !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", cycle_count, cap_min_cost, cap_match_count);
    end
  endtask

  task automatic test_identity_pass();
    apply_reset();
    make_table(1'b1); gold_min = 8; gold_match = 1;
    load_all(1'b1);
    repeat (500) @(negedge CLK);
    fire_valid(8, 1);
    compared++;
    if ({done, pass, timeout} !== 3'b110 || cycle_count !== 31'd500) begin
      mismatched++;
      $display("[TB] FAIL identity_result: got dpt=%b cyc=%0d expected 110 cyc=500", {done, pass, timeout}, cycle_count);
    end
    compared++;
    if (cap_min_cost !== 9'd8 || cap_match_count !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL identity_capture: got %0d/%0d expected 8/1", cap_min_cost, cap_match_count);
    end
  endtask

  task automatic test_back_to_back();
    repeat (5) @(negedge CLK);
    fire_valid(3, 2);
    repeat (3) @(negedge CLK);
    compared++;
    if ({done, pass, timeout, jam_rst} !== 4'b1100 || cycle_count !== 31'd500 ||
        cap_min_cost !== 9'd8 || cap_match_count !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL second_valid: got flags=%b cyc=%0d cap=%0d/%0d expected 1100 500 8/1",
               {done, pass, timeout, jam_rst}, cycle_count, cap_min_cost, cap_match_count);
    end
  endtask

  task automatic test_cost_sweep();
    apply_reset();
    make_table(1'b0); gold_min = int'($urandom_range(0, 511)); gold_match = int'($urandom_range(0, 15));
    load_all(1'b1);
    for (int i = 0; i < 64; i++) begin
      W = 3'(i / 8); J = 3'(i % 8);
      #1;
      compared++;
      if (Cost !== 7'(model_cost[i])) begin
        mismatched++;
        $display("[TB] FAIL cost_w%0d_j%0d: got %0d expected %0d", i / 8, i % 8, Cost, model_cost[i]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_mismatch();
    apply_reset();
    make_table(1'b1); gold_min = 8; gold_match = 1;
    load_all(1'b0);
    repeat (37) @(negedge CLK);
    fire_valid(9, 1);
    compared++;
    if ({done, pass, timeout} !== 3'b100 || cap_min_cost !== 9'd9 || cap_match_count !== 4'd1 ||
        cycle_count !== 31'd37) begin
      mismatched++;
      $display("[TB] FAIL mismatch_result: got dpt=%b cap=%0d/%0d cyc=%0d expected 100 9/1 37",
               {done, pass, timeout}, cap_min_cost, cap_match_count, cycle_count);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      int at, mc, mt;
      bit exp_pass;
      apply_reset();
      make_table(1'b0); gold_min = int'($urandom_range(0, 511)); gold_match = int'($urandom_range(0, 15));
      load_all(1'b1);
      at = int'($urandom_range(1, 60));
      exp_pass = 1'($urandom_range(0, 1));
      mc = gold_min; mt = gold_match;
      if (!exp_pass) begin
        if ($urandom_range(0, 1) == 0) mc = gold_min ^ (1 << $urandom_range(0, 8));
        else mt = gold_match ^ (1 << $urandom_range(0, 3));
      end
      repeat (at) @(negedge CLK);
      fire_valid(mc, mt);
      compared++;
      if ({done, pass, timeout} !== {1'b1, exp_pass, 1'b0} || cycle_count !== 31'(at) ||
          cap_min_cost !== 9'(mc) || cap_match_count !== 4'(mt)) begin
        mismatched++;
        $display("[TB] FAIL random_run_%0d: got dpt=%b cyc=%0d cap=%0d/%0d expected %b cyc=%0d cap=%0d/%0d",
                 r, {done, pass, timeout}, cycle_count, cap_min_cost, cap_match_count,
                 {1'b1, exp_pass, 1'b0}, at, mc, mt);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    make_table(1'b0); gold_min = 100; gold_match = 4;
    load_all(1'b0);
    repeat (99) @(negedge CLK);
    compared++;
    if (to_done !== 1'b0 || to_cycle_count !== 31'd99) begin
      mismatched++;
      $display("[TB] FAIL timeout_edge: got done=%b cyc=%0d expected 0 99", to_done, to_cycle_count);
    end
    @(negedge CLK);
    compared++;
    if ({to_done, to_pass, to_timeout} !== 3'b101 || to_cycle_count !== 31'd99) begin
      mismatched++;
      $display("[TB] FAIL timeout_fire: got dpt=%b cyc=%0d expected 101 99", {to_done, to_pass, to_timeout}, to_cycle_count);
    end
    repeat (50) @(negedge CLK);
    fire_valid(100, 4);
    compared++;
    if ({to_done, to_pass, to_timeout} !== 3'b101 || to_cycle_count !== 31'd99 ||
        to_cap_min_cost !== 9'd0 || to_cap_match_count !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL late_valid: got dpt=%b cyc=%0d cap=%0d/%0d expected 101 99 0/0",
               {to_done, to_pass, to_timeout}, to_cycle_count, to_cap_min_cost, to_cap_match_count);
    end
    compared++;
    if ({done, pass, timeout} !== 3'b110 || cycle_count !== 31'd150) begin
      mismatched++;
      $display("[TB] FAIL long_timeout_run: got dpt=%b cyc=%0d expected 110 150", {done, pass, timeout}, cycle_count);
    end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    make_table(1'b0); gold_min = 5; gold_match = 2;
    for (int i = 0; i < 31; i++) begin
      load_valid = 1'b1; load_data = beat_word(i);
      @(negedge CLK);
    end
    load_valid = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    compared++;
    if ({load_ready, jam_rst, done} !== 3'b110) begin
      mismatched++;
      $display("[TB] FAIL mid_load_reset: got %b expected 110", {load_ready, jam_rst, done});
    end
    make_table(1'b0); gold_min = int'($urandom_range(0, 511)); gold_match = int'($urandom_range(0, 15));
    load_all(1'b1);
    repeat (20) @(negedge CLK);
    fire_valid(gold_min, gold_match);
    compared++;
    if ({done, pass, timeout} !== 3'b110 || cycle_count !== 31'd20) begin
      mismatched++;
      $display("[TB] FAIL reload_run: got dpt=%b cyc=%0d expected 110 20", {done, pass, timeout}, cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_identity_pass();
    test_back_to_back();
    test_cost_sweep();
    test_mismatch();
    test_random_runs();
    test_timeout();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Hardware responder for the JAM job-assignment datapath. It owns the 8x8 worker/job cost table and answers JAM's (W,J) lookups with Cost in the same cycle.
- Before a run, it loads the table and golden results through a valid/ready stream, then holds JAM in reset.
- During the run, it counts cycles and waits for Valid.
- On Valid it captures MinCost/MatchCount and compares them against the golden values. It raises a timeout if Valid never arrives.
- It replaces the behavioural cost ROM and checker on FPGA/emulation builds.

Parameters:
- TIMEOUT_CYCLES, 10000000, maximum run cycles before timeout is flagged.
- RST_HOLD, 3, cycles jam_rst stays high after the load completes.
- CYC_W, 31, cycle counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- load_valid  in  1  load beat valid.
- load_data  in  9  load beat payload.
- load_ready  out  1  server accepts load beats.
- jam_rst  out  1  reset driven to JAM.
- W  in  3  worker index from JAM.
- J  in  3  job index from JAM.
- Cost  out  7  cost[W][J].
- MinCost  in  9  JAM result.
- MatchCount  in  4  JAM result.
- Valid  in  1  JAM result strobe.
- done  out  1  run finished (pass, fail, or timeout).
- pass  out  1  captured results equal golden values.
- timeout  out  1  Valid not seen within TIMEOUT_CYCLES.
- cycle_count  out  CYC_W  cycles spent in RUN.
- cap_min_cost  out  9  captured MinCost.
- cap_match_count  out  4  captured MatchCount.

Behaviour:
- Reset values: load_ready=1, jam_rst=1, done=0, pass=0, timeout=0, cycle_count=0, cap_*=0, FSM=LOAD, beat counter=0. The table contents are not cleared.
- A beat transfers on any clock edge where load_valid && load_ready.
- Beats 0..63 carry the table: entry index = beat number = 8*W+J, row-major, value = load_data[6:0]. Bits [8:7] of these beats are ignored.
- Beat 64 carries gold_min_cost = load_data[8:0].
- Beat 65 carries gold_match_count = load_data[3:0].
- Cost is purely combinational: table[{W,J}], valid in the same cycle W/J change. No read latency is allowed, because JAM samples Cost in that cycle.
- FSM states:
  - LOAD: load_ready=1, jam_rst=1. After the edge accepting beat 65, load_ready=0 and go to HOLD with hold counter=0.
  - HOLD: jam_rst=1 for exactly RST_HOLD cycles, then go to RUN. jam_rst=0 from the first RUN cycle.
  - RUN: cycle_count increments every cycle, saturating at all-ones.
    - If Valid=1: latch cap_min_cost and cap_match_count, set pass = (MinCost==gold_min_cost && MatchCount==gold_match_count), done=1, go to DONE. cycle_count does not increment on the capture edge.
    - Else, if cycle_count == TIMEOUT_CYCLES-1: timeout=1, done=1, pass=0, go to DONE.
    - If Valid arrives on the same edge the timeout would fire, Valid wins.
  - DONE: all outputs hold. Valid is ignored and only the first Valid counts. jam_rst stays 0. Leave only via RST.
- Reset mid-operation: RST during any state returns to LOAD with reset values, and a new full 66-beat load is required. A partial load is discarded by resetting the beat counter; the table memory may keep stale values until it is rewritten.
- load_valid outside LOAD is ignored because load_ready=0.
- Out-of-range indices are impossible: W and J are 3 bits and the table has 64 entries.

Decomposition:
- jam_pkg holds:
  - localparams: N_WORKER=8, N_JOB=8, COST_W=7, MINCOST_W=9, MATCH_W=4, TABLE_BEATS=64, LOAD_BEATS=66.
  - typedef enum logic[1:0] {LOAD, HOLD, RUN, DONE} srv_state_t.
  - typedef logic[COST_W-1:0] cost_t.
- One sub-module, jam_cost_table: 64x7 register file with a synchronous write port and an asynchronous read port. It implements the write enable and the combinational Cost read.
- The FSM, counters and compare logic stay in the top.

Test Plan:
- Identity table (cost[w][j] = 1 if w==j, else 9), golden 8/1; JAM model drives Valid with MinCost=8, MatchCount=1 at run cycle 500 -> done=1, pass=1, cycle_count=500, cap_min_cost=8, cap_match_count=1.
- After a random load, sweep W,J over all 64 pairs, one per cycle -> Cost equals the loaded value in the same cycle for every pair.
- Mismatch: golden 8/1, Valid with MinCost=9, MatchCount=1 -> done=1, pass=0, cap_min_cost=9.
- Timeout: TIMEOUT_CYCLES=100, Valid held 0 -> timeout=1, done=1, pass=0, cycle_count=99; a Valid at cycle 150 is ignored.
- Handshake:
  - load_valid toggles randomly -> exactly 66 beats accepted and load_ready falls after beat 65.
  - jam_rst stays high exactly RST_HOLD=3 cycles after the last beat.
  - A second Valid in DONE changes nothing.
- RST asserted after beat 30 -> FSM in LOAD, beat counter 0; a fresh 66-beat load completes a normal pass run.
